// File: rtl/nand_share_arbiter_if.sv
// Bundle of request, operand and result signals between the client side and the
// shared NAND arbiter.
interface nand_share_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ*WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]       gnt;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [IDW-1:0]           out_id;
  logic                     busy;

  // Client side: raises requests, supplies operands, consumes results.
  modport master (
    output req, a_in, b_in, out_ready,
    input  gnt, out_valid, out_data, out_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req, a_in, b_in, out_ready,
    output gnt, out_valid, out_data, out_id, busy
  );
endinterface

// File: rtl/nand_share_arbiter.sv
// Round-robin arbiter in front of one registered WIDTH-bit NAND datapath.
// A winner is picked only in IDLE; its result sits in a single output register
// (HOLD) until the consumer takes it, then the FSM returns to IDLE.
module nand_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  nand_share_arbiter_if.slave     bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_valid;
  logic [WIDTH-1:0]   r_data;
  logic [IDW-1:0]     r_id;

  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [IDW-1:0]     w_idx;
  logic [IDW-1:0]     w_ptr_nxt;
  logic [NUM_REQ-1:0] w_onehot;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;

  // Search REQ starting at PTR, wrapping modulo NUM_REQ; first set bit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Winner-derived values: operands of losers never reach the datapath.
  always_comb begin
    w_onehot  = NUM_REQ'(1) << w_win;
    w_a       = bus.a_in[int'(w_win)*WIDTH +: WIDTH];
    w_b       = bus.b_in[int'(w_win)*WIDTH +: WIDTH];
    w_ptr_nxt = (int'(w_win) == NUM_REQ-1) ? '0 : w_win + IDW'(1);
  end

  // Two-state FSM: arbitrate and capture in IDLE, hold result until accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_onehot;
            r_data  <= ~(w_a & w_b);
            r_id    <= w_win;
            r_valid <= 1'b1;
            r_ptr   <= w_ptr_nxt;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Data/ID are left untouched on accept so they keep their last value.
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_id    = r_id;
  assign bus.busy      = (r_state == S_HOLD);
endmodule

// File: tb/tb_nand_share_arbiter.sv
// Bench for nand_share_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_nand_share_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: what the consumer should see.
  logic [N-1:0] m_gnt;
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_id;
  int           m_ptr;
  logic         m_busy;

  nand_share_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  nand_share_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"},   32'(bus.gnt),       32'(m_gnt));
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".data"},  32'(bus.out_data),  32'(m_data));
    chk({tag, ".id"},    32'(bus.out_id),    32'(m_id));
    chk({tag, ".busy"},  32'(bus.busy),      32'(m_busy));
  endtask

  task automatic model_reset();
    m_gnt = '0; m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_busy = 1'b0;
  endtask

  // Advance the model by one clock using current inputs, clock the DUT, compare.
  task automatic cycle(input string tag);
    int w;
    w = -1;
    if (!m_busy) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_gnt   = '0;
        m_gnt[w] = 1'b1;
        m_data  = ~(bus.a_in[w*W +: W] & bus.b_in[w*W +: W]);
        m_id    = w;
        m_valid = 1'b1;
        m_busy  = 1'b1;
        m_ptr   = (w + 1) % N;
      end else begin
        m_gnt = '0;
      end
    end else begin
      m_gnt = '0;
      if (bus.out_ready) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in[i*W +: W] = a;
    bus.b_in[i*W +: W] = b;
  endtask

  initial begin
    bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.out_ready = 1'b0;
    model_reset();

    // Reset state
    #1;
    check_all("reset");
    @(posedge clk); #1;
    check_all("reset_edge");
    rst = 1'b0;

    // 1: single request from 0
    set_op(0, 8'hF0, 8'h3C);
    bus.req = 4'b0001; bus.out_ready = 1'b1;
    cycle("t1_grant");
    chk("t1_data_const", 32'(bus.out_data), 32'hCF);
    chk("t1_gnt_const",  32'(bus.gnt),      32'h1);
    bus.req = '0;
    cycle("t1_drop");
    chk("t1_valid_low", 32'(bus.out_valid), 32'h0);

    // 2: fresh reset, all requesting -> rotation
    rst = 1'b1; #1; model_reset(); rst = 1'b0;
    bus.req = 4'b1111; bus.out_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      cycle("t2_grant");
      chk("t2_rot", 32'(bus.gnt), 32'(1 << (g % 4)));
      cycle("t2_hold");
    end

    // 3: backpressure
    bus.req = 4'b0100;
    cycle("t3_grant2");
    chk("t3_id2", 32'(bus.out_id), 32'd2);
    bus.req = 4'b0010; bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle("t3_stall");
      chk("t3_stall_gnt", 32'(bus.gnt), 32'h0);
    end
    bus.out_ready = 1'b1;
    cycle("t3_accept");
    cycle("t3_grant1");
    chk("t3_gnt1", 32'(bus.gnt), 32'h2);

    // 4: PTR=3 after grant to 2, REQ=0101 -> requester 0
    bus.req = '0;
    cycle("t4_leave");
    bus.req = 4'b0100;
    cycle("t4_grant2");
    bus.req = '0;
    cycle("t4_idle");
    bus.req = 4'b0101;
    cycle("t4_grant0");
    chk("t4_gnt0", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    cycle("t4_idle2");

    // 5: operand corners on requester 3
    for (int p = 0; p < 3; p++) begin
      logic [W-1:0] a, b, e;
      a = (p == 0) ? 8'h00 : (p == 1) ? 8'hFF : 8'hAA;
      b = (p == 0) ? 8'h00 : (p == 1) ? 8'hFF : 8'h55;
      e = (p == 1) ? 8'h00 : 8'hFF;
      set_op(3, a, b);
      bus.req = 4'b1000;
      cycle("t5_grant");
      chk("t5_data", 32'(bus.out_data), 32'(e));
      chk("t5_id",   32'(bus.out_id),   32'd3);
      bus.req = '0;
      cycle("t5_idle");
    end

    // 6: async reset in HOLD
    bus.out_ready = 1'b0;
    bus.req = 4'b0010;
    cycle("t6_grant");
    bus.req = '0;
    cycle("t6_hold");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    @(posedge clk); #1;
    check_all("t6_in_rst");
    rst = 1'b0;
    bus.req = 4'b1000; bus.out_ready = 1'b1;
    cycle("t6_regrant");
    chk("t6_gnt3", 32'(bus.gnt), 32'h8);
    bus.req = '0;
    cycle("t6_idle");

    // Random traffic, losers' operands randomized every cycle
    for (int r = 0; r < 300; r++) begin
      bus.req       = N'($urandom_range(0, (1 << N) - 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.a_in      = {$urandom, $urandom};
      bus.b_in      = {$urandom, $urandom};
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
